// File: rtl/fp_op_scheduler_if.sv
// Bundle of requester, shared-core and output-side signals around the FP op scheduler.
// The scheduler uses the master modport; its environment uses the slave modport.
interface fp_op_scheduler_if;
    logic        startA;
    logic        startB;
    logic [31:0] xA;
    logic [31:0] yA;
    logic [31:0] xB;
    logic [31:0] yB;
    logic        coreStart;
    logic [31:0] coreX;
    logic [31:0] coreY;
    logic        coreDone;
    logic [31:0] coreResult;
    logic        outReady;
    logic [31:0] outBus;
    logic        outSrc;
    logic        outAccepted;
    logic        busyA;
    logic        busyB;
    logic        timeoutErr;

    modport master (
        input  startA, startB, xA, yA, xB, yB, coreDone, coreResult, outAccepted,
        output coreStart, coreX, coreY, outReady, outBus, outSrc, busyA, busyB, timeoutErr
    );

    modport slave (
        output startA, startB, xA, yA, xB, yB, coreDone, coreResult, outAccepted,
        input  coreStart, coreX, coreY, outReady, outBus, outSrc, busyA, busyB, timeoutErr
    );
endinterface

// File: rtl/fp_op_scheduler.sv
// Shares one FP core between requesters A and B: edge-triggered requests, round-robin
// grant, bounded wait for the core, and a ready/accept handshake toward the output side.
module fp_op_scheduler #(
    parameter int TIMEOUT = 200
) (
    input  logic              clk,
    input  logic              rst,
    fp_op_scheduler_if.master bus
);
    localparam int          CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;
    localparam logic        SRC_A = 1'b0;
    localparam logic        SRC_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT,
        RELEASE
    } state_t;

    state_t      state_q, state_d;
    logic        start_a_prev_q, start_b_prev_q;
    logic        pend_a_q, pend_a_d;
    logic        pend_b_q, pend_b_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic        core_start_q, core_start_d;
    logic [31:0] core_x_q, core_x_d;
    logic [31:0] core_y_q, core_y_d;
    logic [31:0] out_bus_q, out_bus_d;
    logic        out_ready_q, out_ready_d;
    logic        out_src_q, out_src_d;
    logic        timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic rise_a, rise_b;
    logic in_service_a, in_service_b;
    logic grant_b;

    always_comb begin
        state_d       = state_q;
        pend_a_d      = pend_a_q;
        pend_b_d      = pend_b_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        core_start_d  = 1'b0;
        core_x_d      = core_x_q;
        core_y_d      = core_y_q;
        out_bus_d     = out_bus_q;
        out_src_d     = out_src_q;
        timeout_err_d = timeout_err_q;
        wait_cnt_d    = wait_cnt_q;
        grant_b       = 1'b0;

        rise_a       = bus.startA & ~start_a_prev_q;
        rise_b       = bus.startB & ~start_b_prev_q;
        in_service_a = (state_q != IDLE) && (owner_q == SRC_A);
        in_service_b = (state_q != IDLE) && (owner_q == SRC_B);

        // A new edge only counts when that requester has nothing outstanding.
        if (rise_a && !pend_a_q && !in_service_a) pend_a_d = 1'b1;
        if (rise_b && !pend_b_q && !in_service_b) pend_b_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (pend_a_q || pend_b_q) begin
                    grant_b = pend_b_q && (!pend_a_q || (last_grant_q == SRC_A));
                    owner_d = grant_b;
                    if (grant_b) begin
                        core_x_d = bus.xB;
                        core_y_d = bus.yB;
                        pend_b_d = 1'b0;
                    end else begin
                        core_x_d = bus.xA;
                        core_y_d = bus.yA;
                        pend_a_d = 1'b0;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                core_start_d = 1'b1;
                wait_cnt_d   = '0;
                state_d      = WAIT;
            end
            WAIT: begin
                if (bus.coreDone) begin
                    out_bus_d = bus.coreResult;
                    out_src_d = owner_q;
                    state_d   = OUT;
                end else if (wait_cnt_q >= CNT_W'(TIMEOUT - 1)) begin
                    // Give up on the core and hand back a quiet NaN instead.
                    wait_cnt_d    = CNT_W'(TIMEOUT);
                    timeout_err_d = 1'b1;
                    out_bus_d     = QNAN;
                    out_src_d     = owner_q;
                    state_d       = OUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            OUT: begin
                if (bus.outAccepted) state_d = RELEASE;
            end
            RELEASE: begin
                if (!bus.outAccepted) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        out_ready_d = (state_d == OUT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            start_a_prev_q <= 1'b0;
            start_b_prev_q <= 1'b0;
            pend_a_q       <= 1'b0;
            pend_b_q       <= 1'b0;
            owner_q        <= SRC_A;
            last_grant_q   <= SRC_B;
            core_start_q   <= 1'b0;
            core_x_q       <= '0;
            core_y_q       <= '0;
            out_bus_q      <= '0;
            out_ready_q    <= 1'b0;
            out_src_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
            wait_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            start_a_prev_q <= bus.startA;
            start_b_prev_q <= bus.startB;
            pend_a_q       <= pend_a_d;
            pend_b_q       <= pend_b_d;
            owner_q        <= owner_d;
            last_grant_q   <= last_grant_d;
            core_start_q   <= core_start_d;
            core_x_q       <= core_x_d;
            core_y_q       <= core_y_d;
            out_bus_q      <= out_bus_d;
            out_ready_q    <= out_ready_d;
            out_src_q      <= out_src_d;
            timeout_err_q  <= timeout_err_d;
            wait_cnt_q     <= wait_cnt_d;
        end
    end

    assign bus.coreStart  = core_start_q;
    assign bus.coreX      = core_x_q;
    assign bus.coreY      = core_y_q;
    assign bus.outReady   = out_ready_q;
    assign bus.outBus     = out_bus_q;
    assign bus.outSrc     = out_src_q;
    assign bus.timeoutErr = timeout_err_q;
    assign bus.busyA      = pend_a_q | in_service_a;
    assign bus.busyB      = pend_b_q | in_service_b;
endmodule

// File: tb/tb_fp_op_scheduler.sv
// Directed and randomized bench for fp_op_scheduler; a transaction-level model predicts
// which requester is served, with which operands and result, and the sticky error flag.
module tb_fp_op_scheduler;
    localparam int          TIMEOUT = 200;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic        SRC_A   = 1'b0;
    localparam logic        SRC_B   = 1'b1;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass = 0;
    int   start_pulses = 0;
    int   pulses_before;
    logic model_last = SRC_B;
    logic model_err = 1'b0;
    logic [31:0] fix_x, fix_y, fix_r;
    bit   seen;

    fp_op_scheduler_if bus ();

    fp_op_scheduler #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.coreStart === 1'b1) start_pulses <= start_pulses + 1;
    end

    // Round-robin rule: on a tie the requester not served last wins.
    function automatic logic pick(input bit pa, input bit pb, input logic last);
        if (pa && pb) return ~last;
        return pb ? SRC_B : SRC_A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.startA = 1'b0;
        bus.startB = 1'b0;
        bus.coreDone = 1'b0;
        bus.outAccepted = 1'b0;
        #1;
        check("rst.coreStart", 32'(bus.coreStart), 32'd0);
        check("rst.outReady", 32'(bus.outReady), 32'd0);
        check("rst.outBus", bus.outBus, 32'd0);
        check("rst.outSrc", 32'(bus.outSrc), 32'd0);
        check("rst.coreX", bus.coreX, 32'd0);
        check("rst.coreY", bus.coreY, 32'd0);
        check("rst.timeoutErr", 32'(bus.timeoutErr), 32'd0);
        check("rst.busyA", 32'(bus.busyA), 32'd0);
        check("rst.busyB", 32'(bus.busyB), 32'd0);
        model_last = SRC_B;
        model_err  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic exp_src, input logic [31:0] exp_x,
                          input logic [31:0] exp_y, input logic [31:0] result, input int lat,
                          input bit no_done, input bit early_acc, input int start_budget);
        bit          got;
        int          k;
        logic [31:0] exp_bus;
        got = 1'b0;
        for (int i = 0; i < start_budget && !got; i++) begin
            @(negedge clk);
            got = (bus.coreStart === 1'b1);
        end
        check({tag, ".start"}, 32'(got), 32'd1);
        if (!got) return;
        check({tag, ".coreX"}, bus.coreX, exp_x);
        check({tag, ".coreY"}, bus.coreY, exp_y);
        check({tag, ".busy_serv"}, 32'(exp_src ? bus.busyB : bus.busyA), 32'd1);
        if (no_done) begin
            model_err = 1'b1;
            exp_bus   = QNAN;
            k = 0;
            got = 1'b0;
            while (!got && k < TIMEOUT + 20) begin
                @(negedge clk);
                k++;
                got = (bus.outReady === 1'b1);
            end
            check({tag, ".timeout_cycles"}, 32'(k), 32'(TIMEOUT));
        end else begin
            exp_bus = result;
            repeat (lat) @(negedge clk);
            bus.coreDone    = 1'b1;
            bus.coreResult  = result;
            bus.outAccepted = early_acc;
            @(negedge clk);
            bus.coreDone   = 1'b0;
            bus.coreResult = $urandom;
        end
        check({tag, ".outReady"}, 32'(bus.outReady), 32'd1);
        check({tag, ".outBus"}, bus.outBus, exp_bus);
        check({tag, ".outSrc"}, 32'(bus.outSrc), 32'(exp_src));
        check({tag, ".timeoutErr"}, 32'(bus.timeoutErr), 32'(model_err));
        if (early_acc) begin
            @(negedge clk);
        end else begin
            bus.coreDone   = 1'b1;
            bus.coreResult = ~exp_bus;
            @(negedge clk);
            bus.coreDone = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check({tag, ".hold_ready"}, 32'(bus.outReady), 32'd1);
            check({tag, ".hold_bus"}, bus.outBus, exp_bus);
            bus.outAccepted = 1'b1;
            @(negedge clk);
        end
        check({tag, ".ready_drop"}, 32'(bus.outReady), 32'd0);
        repeat (2) @(negedge clk);
        check({tag, ".busy_release"}, 32'(exp_src ? bus.busyB : bus.busyA), 32'd1);
        bus.outAccepted = 1'b0;
        @(negedge clk);
        check({tag, ".busy_done"}, 32'(exp_src ? bus.busyB : bus.busyA), 32'd0);
        model_last = exp_src;
    endtask

    task automatic request_pair(input string tag, input bit pa, input bit pb, input bit early);
        logic [31:0] ox [2];
        logic [31:0] oy [2];
        logic [31:0] res [2];
        logic first, second;
        for (int i = 0; i < 2; i++) begin
            ox[i]  = $urandom;
            oy[i]  = $urandom;
            res[i] = $urandom;
        end
        @(negedge clk);
        bus.xA = ox[0];
        bus.yA = oy[0];
        bus.xB = ox[1];
        bus.yB = oy[1];
        bus.startA = pa;
        bus.startB = pb;
        @(negedge clk);
        bus.startA = 1'b0;
        bus.startB = 1'b0;
        first  = pick(pa, pb, model_last);
        second = ~first;
        run_op({tag, ".first"}, first, ox[first], oy[first], res[first],
               $urandom_range(1, 8), 1'b0, early, 40);
        if (pa && pb)
            run_op({tag, ".second"}, second, ox[second], oy[second], res[second],
                   $urandom_range(1, 8), 1'b0, 1'b0, 40);
    endtask

    initial begin
        rst = 1'b0;
        bus.startA = 1'b0;
        bus.startB = 1'b0;
        bus.xA = '0;
        bus.yA = '0;
        bus.xB = '0;
        bus.yB = '0;
        bus.coreDone = 1'b0;
        bus.coreResult = '0;
        bus.outAccepted = 1'b0;
        do_reset();

        // Single request with exact request-to-start latency
        @(negedge clk);
        bus.xA = 32'h3F80_0000;
        bus.yA = 32'h4000_0000;
        bus.startA = 1'b1;
        pulses_before = start_pulses;
        @(negedge clk);
        check("single.busyA_pend", 32'(bus.busyA), 32'd1);
        check("single.no_start_1", 32'(bus.coreStart), 32'd0);
        bus.startA = 1'b0;
        @(negedge clk);
        check("single.no_start_2", 32'(bus.coreStart), 32'd0);
        run_op("single", SRC_A, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5, 1'b0, 1'b0, 1);
        check("single.pulses", 32'(start_pulses - pulses_before), 32'd1);

        // Simultaneous requests right after reset
        do_reset();
        request_pair("tie", 1'b1, 1'b1, 1'b0);

        // B's edge lands in the same cycle A is granted
        @(negedge clk);
        fix_x = $urandom; fix_y = $urandom;
        bus.xA = fix_x; bus.yA = fix_y;
        bus.xB = ~fix_x; bus.yB = ~fix_y;
        bus.startA = 1'b1;
        @(negedge clk);
        bus.startA = 1'b0;
        bus.startB = 1'b1;
        @(negedge clk);
        bus.startB = 1'b0;
        check("coincide.busyB", 32'(bus.busyB), 32'd1);
        run_op("coincide.A", SRC_A, fix_x, fix_y, 32'h1234_5678, 2, 1'b0, 1'b0, 40);
        run_op("coincide.B", SRC_B, ~fix_x, ~fix_y, 32'h8765_4321, 3, 1'b0, 1'b1, 40);

        // A alone, then both together
        request_pair("rr.a", 1'b1, 1'b0, 1'b0);
        request_pair("rr.both", 1'b1, 1'b1, 1'b0);

        // Re-edge while in service and a long held level give one operation
        @(negedge clk);
        fix_x = $urandom; fix_y = $urandom; fix_r = $urandom;
        bus.xA = fix_x; bus.yA = fix_y;
        bus.startA = 1'b1;
        pulses_before = start_pulses;
        @(negedge clk);
        bus.startA = 1'b0;
        @(negedge clk);
        bus.startA = 1'b1;
        run_op("held", SRC_A, fix_x, fix_y, fix_r, 3, 1'b0, 1'b0, 1);
        repeat (50) @(negedge clk);
        check("held.pulses", 32'(start_pulses - pulses_before), 32'd1);
        check("held.busyA", 32'(bus.busyA), 32'd0);
        bus.startA = 1'b0;

        // Core never answers
        @(negedge clk);
        fix_x = $urandom; fix_y = $urandom;
        bus.xB = fix_x; bus.yB = fix_y;
        bus.startB = 1'b1;
        @(negedge clk);
        bus.startB = 1'b0;
        run_op("timeout", SRC_B, fix_x, fix_y, 32'd0, 0, 1'b1, 1'b0, 40);
        request_pair("after_timeout", 1'b1, 1'b0, 1'b0);
        do_reset();

        // Reset while waiting on the core
        @(negedge clk);
        bus.xA = $urandom; bus.yA = $urandom;
        bus.startA = 1'b1;
        @(negedge clk);
        bus.startA = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.coreStart === 1'b1);
        end
        check("midrst.start", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        do_reset();
        @(negedge clk);
        bus.coreDone = 1'b1;
        bus.coreResult = $urandom;
        @(negedge clk);
        bus.coreDone = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst.no_ready", 32'(bus.outReady), 32'd0);
        check("midrst.busyA", 32'(bus.busyA), 32'd0);
        request_pair("midrst.after", 1'b0, 1'b1, 1'b0);

        // Random mixes of requesters, latencies and accept timing
        for (int n = 0; n < 8; n++) begin
            int mode;
            mode = $urandom_range(1, 3);
            request_pair("rand", (mode != 2), (mode != 1), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
